// File: rtl/tetris_pkg.sv
// Shared tetromino colour definitions: nibble RGB triple, default palette,
// named block types and the nibble-to-channel-width scaling helper.
package tetris_pkg;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb4_t;

   typedef enum logic [2:0] {
      NOBLOCK = 3'd0,
      CYAN    = 3'd1,
      YELLOW  = 3'd2,
      PURPLE  = 3'd3,
      GREEN   = 3'd4,
      RED     = 3'd5,
      BLUE    = 3'd6,
      ORANGE  = 3'd7
   } block_type_e;

   // Packed with index 7 first so DEFAULT_PALETTE[k] is block type k.
   localparam rgb4_t [7:0] DEFAULT_PALETTE = {
      12'hF70,   // ORANGE
      12'h00F,   // BLUE
      12'hF00,   // RED
      12'h0F0,   // GREEN
      12'hC0C,   // PURPLE
      12'hFF0,   // YELLOW
      12'h0FF,   // CYAN
      12'h666    // NOBLOCK
   };

   // Replicates the nibble MSB-first into ch_w bits (ch_w <= 32), so the
   // narrowest widths keep the nibble's top bits and wider ones repeat it.
   function automatic logic [31:0] scale_nibble(input logic [3:0] n, input int ch_w);
      logic [31:0] res;
      res = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < ch_w) res[5'(ch_w - 1 - i)] = n[2'(3 - (i % 4))];
      end
      return res;
   endfunction

endpackage

// File: rtl/palette_lut_blink_timer.sv
// Frame-synchronised blink timer: counts frame ticks and flips the blink
// phase each time the count wraps after BLINK_FRAMES ticks.
module blink_timer #(
   parameter int BLINK_FRAMES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic frame_tick,
   output logic blink_phase
);

   localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             phase_q, phase_d;

   // Advance the counter only on frame ticks; wrap toggles the phase.
   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (frame_tick) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Counter and phase registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign blink_phase = phase_q;

endmodule

// File: rtl/palette_lut.sv
// Programmable block-type to RGB palette with one-cycle registered lookup,
// write-through bypass, dim mode and blink/flash override.
module palette_lut
   import tetris_pkg::*;
#(
   parameter int TYPE_W       = 3,
   parameter int CH_W         = 4,
   parameter int BLINK_FRAMES = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pix_valid,
   input  logic [TYPE_W-1:0]   pix_type,
   input  logic                pix_flash,
   input  logic                dim,
   input  logic                frame_tick,
   input  logic                wr_en,
   input  logic [TYPE_W-1:0]   wr_addr,
   input  logic [3*CH_W-1:0]   wr_data,
   output logic [3*CH_W-1:0]   color,
   output logic                color_valid,
   output logic                blink_phase
);

   localparam int DEPTH = 2**TYPE_W;
   localparam int PIX_W = 3*CH_W;

   // Reset value of entry idx, scaled from the nibble table to CH_W bits.
   function automatic logic [PIX_W-1:0] default_entry(input int idx);
      rgb4_t       n;
      logic [31:0] r, g, b;
      n = (idx < 8) ? DEFAULT_PALETTE[idx[2:0]] : DEFAULT_PALETTE[NOBLOCK];
      r = scale_nibble(n.r, CH_W);
      g = scale_nibble(n.g, CH_W);
      b = scale_nibble(n.b, CH_W);
      return {r[CH_W-1:0], g[CH_W-1:0], b[CH_W-1:0]};
   endfunction

   // Halve each channel independently; bits never cross channel boundaries.
   function automatic logic [PIX_W-1:0] dim_pix(input logic [PIX_W-1:0] p);
      logic [PIX_W-1:0] res;
      for (int c = 0; c < 3; c++) begin
         res[c*CH_W +: CH_W] = p[c*CH_W +: CH_W] >> 1;
      end
      return res;
   endfunction

   logic [PIX_W-1:0] pal_q [DEPTH];
   logic [PIX_W-1:0] pal_d [DEPTH];
   logic [PIX_W-1:0] color_q, color_d;
   logic             color_valid_q, color_valid_d;
   logic             phase;
   logic [PIX_W-1:0] base;

   blink_timer #(
      .BLINK_FRAMES (BLINK_FRAMES)
   ) u_blink_timer (
      .clk         (clk),
      .rst         (rst),
      .frame_tick  (frame_tick),
      .blink_phase (phase)
   );

   // Next palette contents: a single entry may be overwritten per cycle.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         pal_d[i] = pal_q[i];
         if (wr_en && (wr_addr == TYPE_W'(i))) pal_d[i] = wr_data;
      end
   end

   // Lookup stage: bypassed read, then dim, then flash override on top.
   always_comb begin
      color_d       = color_q;
      color_valid_d = pix_valid;
      base          = (wr_en && (wr_addr == pix_type)) ? wr_data : pal_q[pix_type];
      if (pix_valid) begin
         color_d = dim ? dim_pix(base) : base;
         if (pix_flash && phase) color_d = '1;
      end
   end

   // Palette array and output registers; reset reloads the default palette.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) pal_q[i] <= default_entry(i);
         color_q       <= '0;
         color_valid_q <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) pal_q[i] <= pal_d[i];
         color_q       <= color_d;
         color_valid_q <= color_valid_d;
      end
   end

   assign color       = color_q;
   assign color_valid = color_valid_q;
   assign blink_phase = phase;

endmodule
